// File: rtl/operand_fetch_unit_if.sv
// rtl/operand_fetch_unit_if.sv - bank write, fetch request and operand response bundle
//
// Groups every non-clock, non-reset signal of operand_fetch_unit.
// Parameters: WIDTH (data width), AW (address width).
// Write port : wr_en, wr_addr[AW], wr_data[WIDTH]        (master -> slave)
// Request    : req_valid, rs1_addr[AW], rs2_addr[AW]     (master -> slave)
//              req_ready                                 (slave -> master)
// Response   : op_valid, op1[WIDTH], op2[WIDTH]          (slave -> master)
//              op_ready                                  (master -> slave)
interface operand_fetch_unit_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    rs1_addr;
  logic [AW-1:0]    rs2_addr;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;

  modport master (
    output wr_en, wr_addr, wr_data, req_valid, rs1_addr, rs2_addr, op_ready,
    input  req_ready, op_valid, op1, op2
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, req_valid, rs1_addr, rs2_addr, op_ready,
    output req_ready, op_valid, op1, op2
  );
endinterface

// File: rtl/operand_fetch_unit.sv
// rtl/operand_fetch_unit.sv - register bank with two-operand fetch request/response FSM
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; clears FSM, operands and every bank entry
//   bus  - operand_fetch_unit_if.slave (write port, fetch request, operand response)
// Parameters: WIDTH (data bits), DEPTH (bank entries, 2..256), AW (address bits, 2^AW >= DEPTH).
// Optional feature: define OPFETCH_BYPASS_EN to forward a same-cycle bank write
// into an operand being loaded in the READ cycle.
module operand_fetch_unit #(
  parameter int          WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int          AW    = 3
) (
  input logic               clk,
  input logic               rst,
  operand_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    rs1_q, rs1_d;
  logic [AW-1:0]    rs2_q, rs2_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [WIDTH-1:0] bank_q [DEPTH];
  logic [WIDTH-1:0] bank_d [DEPTH];

  logic             wr_ok;
  logic [WIDTH-1:0] rd1, rd2;

  // Writes outside the implemented bank are dropped rather than aliased.
  assign wr_ok = bus.wr_en && (32'(bus.wr_addr) < DEPTH);

  // Bank write path: independent of the FSM state.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      bank_d[i] = bank_q[i];
    end
    if (wr_ok) begin
      bank_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // Operand read values from the captured addresses; out-of-range reads give 0.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (32'(rs1_q) < DEPTH) begin
      rd1 = bank_q[rs1_q];
    end
    if (32'(rs2_q) < DEPTH) begin
      rd2 = bank_q[rs2_q];
    end
`ifdef OPFETCH_BYPASS_EN
    // Same-cycle write wins over the stored value; only sampled in READ.
    if (wr_ok && (bus.wr_addr == rs1_q)) begin
      rd1 = bus.wr_data;
    end
    if (wr_ok && (bus.wr_addr == rs2_q)) begin
      rd2 = bus.wr_data;
    end
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rs1_d   = bus.rs1_addr;
          rs2_d   = bus.rs2_addr;
          state_d = READ;
        end
      end
      READ: begin
        op1_d   = rd1;
        op2_d   = rd2;
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.op_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.op_valid  = (state_q == HOLD);
  assign bus.op1       = op1_q;
  assign bus.op2       = op2_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb/tb_operand_fetch_unit.sv - self-checking bench for operand_fetch_unit
module tb_operand_fetch_unit;
  localparam int WIDTH = 16;
  localparam int DEPTH = 6;
  localparam int AW    = 3;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  bit   running;

  operand_fetch_unit_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  operand_fetch_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = waiting for a request, 1 = one edge after acceptance, 2 = presenting
  logic [WIDTH-1:0] m_bank [256];
  logic [WIDTH-1:0] m_op1, m_op2;
  int               m_phase;
  int               m_a1, m_a2;

  function automatic logic [WIDTH-1:0] m_fetch(input int a);
    if (a >= DEPTH) return '0;
`ifdef OPFETCH_BYPASS_EN
    if (bus.wr_en && int'(bus.wr_addr) < DEPTH && int'(bus.wr_addr) == a) return bus.wr_data;
`endif
    return m_bank[a];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) m_bank[i] = '0;
      m_op1   = '0;
      m_op2   = '0;
      m_phase = 0;
    end else begin
      if (m_phase == 2) begin
        if (bus.op_ready) m_phase = 0;
      end else if (m_phase == 1) begin
        m_op1   = m_fetch(m_a1);
        m_op2   = m_fetch(m_a2);
        m_phase = 2;
      end else if (bus.req_valid) begin
        m_a1    = int'(bus.rs1_addr);
        m_a2    = int'(bus.rs2_addr);
        m_phase = 1;
      end
      if (bus.wr_en && int'(bus.wr_addr) < DEPTH) m_bank[bus.wr_addr] = bus.wr_data;
    end
  end

  // Compare process: outputs checked against the model every cycle.
  always @(negedge clk) begin
    if (running) begin
      check("cyc_req_ready", 32'(bus.req_ready), 32'(m_phase == 0));
      check("cyc_op_valid",  32'(bus.op_valid),  32'(m_phase == 2));
      check("cyc_op1",       32'(bus.op1),       32'(m_op1));
      check("cyc_op2",       32'(bus.op2),       32'(m_op2));
    end
  end

  // ---------------- stimulus helpers (entered just after a rising edge) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = WIDTH'(d);
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_req(input int a1, input int a2);
    bus.req_valid = 1'b1;
    bus.rs1_addr  = AW'(a1);
    bus.rs2_addr  = AW'(a2);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic do_release();
    bus.op_ready = 1'b1;
    step();
    bus.op_ready = 1'b0;
  endtask

  localparam int EXP37 =
`ifdef OPFETCH_BYPASS_EN
    5000;
`else
    100;
`endif

  int accepted;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    running = 1'b0;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.req_valid = 1'b0; bus.rs1_addr = '0; bus.rs2_addr = '0;
    bus.op_ready = 1'b0;

    #12;
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_op_valid",  32'(bus.op_valid),  32'd0);
    check("reset_op1",       32'(bus.op1),       32'd0);
    check("reset_op2",       32'(bus.op2),       32'd0);
    rst = 1'b0;
    running = 1'b1;

    // Basic fetch: op_valid two edges after acceptance.
    do_write(0, 10);
    do_write(1, 1000);
    do_req(0, 1);
    check("read_op_valid", 32'(bus.op_valid), 32'd0);
    step();
    check("fetch_op_valid", 32'(bus.op_valid), 32'd1);
    check("fetch_op1", 32'(bus.op1), 32'd10);
    check("fetch_op2", 32'(bus.op2), 32'd1000);

    // Stall in HOLD while writing the source register.
    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 16'd500;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_op1",       32'(bus.op1),       32'd10);
      check("hold_op_valid",  32'(bus.op_valid),  32'd1);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.wr_en = 1'b0;
    do_release();
    check("release_req_ready", 32'(bus.req_ready), 32'd1);
    check("release_op_valid",  32'(bus.op_valid),  32'd0);

    // Equal addresses with a write to them during READ.
    do_write(2, 100);
    do_req(2, 2);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 16'd5000;
    step();
    bus.wr_en = 1'b0;
    check("rdwr_op1", 32'(bus.op1), 32'(EXP37));
    check("rdwr_op2", 32'(bus.op2), 32'(EXP37));
    do_release();
    do_req(2, 0);
    step();
    check("later_op1", 32'(bus.op1), 32'd5000);
    check("later_op2", 32'(bus.op2), 32'd500);
    do_release();

    // Out-of-range addresses (DEPTH = 6): writes dropped, reads return 0.
    do_write(7, 1234);
    do_write(6, 777);
    do_req(7, 6);
    step();
    check("oor_op1", 32'(bus.op1), 32'd0);
    check("oor_op2", 32'(bus.op2), 32'd0);
    do_release();
    do_req(5, 3);
    step();
    check("unaliased_op1", 32'(bus.op1), 32'd0);
    check("unaliased_op2", 32'(bus.op2), 32'd0);
    do_release();

    // Back-to-back requests with op_ready tied high.
    for (int i = 0; i < DEPTH; i++) do_write(i, 'h1111 * (i + 1));
    bus.op_ready  = 1'b1;
    bus.req_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      bus.rs1_addr = AW'(i % 6);
      bus.rs2_addr = AW'((i + 3) % 8);
      if (bus.req_ready) accepted++;
      step();
    end
    bus.req_valid = 1'b0;
    bus.op_ready  = 1'b0;
    check("b2b_accepts", 32'(accepted), 32'd4);

    // Reset while holding operands.
    do_write(0, 10);
    do_write(1, 20);
    do_req(0, 1);
    step();
    check("prereset_op1", 32'(bus.op1), 32'd10);
    #2 rst = 1'b1;
    #1;
    check("rst_hold_op_valid",  32'(bus.op_valid),  32'd0);
    check("rst_hold_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_hold_op1",       32'(bus.op1),       32'd0);
    check("rst_hold_op2",       32'(bus.op2),       32'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    check("post_rst_op_valid", 32'(bus.op_valid), 32'd0);
    do_req(0, 1);
    step();
    check("post_rst_bank0", 32'(bus.op1), 32'd0);
    check("post_rst_bank1", 32'(bus.op2), 32'd0);
    do_release();

    // Reset while in READ: the pending request is discarded.
    do_write(3, 33);
    do_req(3, 3);
    #2 rst = 1'b1;
    #1;
    check("rst_read_req_ready", 32'(bus.req_ready), 32'd1);
    step();
    rst = 1'b0;
    repeat (3) begin
      step();
      check("rst_read_no_valid", 32'(bus.op_valid), 32'd0);
    end

    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
